// File: rtl/posit_pkg.sv
// Shared posit definitions for the complex-multiplier datapath: special
// encodings, the cmul FSM state type and the posit negation helper.
package posit_pkg;

    localparam int POSIT_W = 16;

    localparam logic [POSIT_W-1:0] POSIT_ZERO = 16'h0000;
    localparam logic [POSIT_W-1:0] POSIT_NAR  = 16'h8000;
    localparam logic [POSIT_W-1:0] POSIT_ONE  = 16'h4000;

    typedef enum logic [2:0] {
        IDLE,
        MUL0,
        MUL1,
        MUL2,
        MUL3,
        ADD_RE,
        ADD_IM,
        DONE
    } cmul_state_e;

    // Posit negation is plain two's complement; 0 and NaR map to themselves.
    function automatic logic [POSIT_W-1:0] posit_neg(input logic [POSIT_W-1:0] x);
        return ~x + POSIT_W'(1);
    endfunction

endpackage

// File: rtl/posit_add.sv
// Single-cycle combinational posit adder; done simply mirrors start.
module posit_add #(
    parameter int N  = 16,
    parameter int es = 3
) (
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         done
);

    localparam int SW = $clog2(N) + es + 3;
    localparam int MW = 2 * N + 1;

    logic                 sa, sb, za, zb, na, nb;
    logic signed [SW-1:0] sca, scb, scl, scs, diff, sco;
    logic [N-1:0]         fa, fb, fl, fs;
    logic                 sl, ss, a_big, lost;
    logic [MW-1:0]        ms, shf;
    logic [MW+1:0]        opl, ops, sum;
    logic [MW:0]          fr;
    logic [N-1:0]         enc;
    int                   lzc;

    posit_decode #(.N(N), .es(es), .SW(SW)) u_dec_a (
        .p(a), .sign(sa), .is_zero(za), .is_nar(na), .scale(sca), .frac(fa)
    );
    posit_decode #(.N(N), .es(es), .SW(SW)) u_dec_b (
        .p(b), .sign(sb), .is_zero(zb), .is_nar(nb), .scale(scb), .frac(fb)
    );

    always_comb begin
        a_big = (sca > scb) || (sca == scb && fa >= fb);
        sl    = a_big ? sa  : sb;
        ss    = a_big ? sb  : sa;
        scl   = a_big ? sca : scb;
        scs   = a_big ? scb : sca;
        fl    = a_big ? fa  : fb;
        fs    = a_big ? fb  : fa;
        diff  = scl - scs;
        ms    = {1'b1, fs, {N{1'b0}}};
        shf   = ms >> diff;
        // Bits shifted past the guard field survive as a sticky LSB.
        lost  = ((shf << diff) != ms);
        opl   = {1'b0, 1'b1, fl, {N{1'b0}}, 1'b0};
        ops   = {1'b0, shf, lost};
        sum   = (sl == ss) ? (opl + ops) : (opl - ops);
        lzc   = 0;
        for (int i = MW + 1; i >= 0; i--) begin
            if (!sum[i] && lzc == MW + 1 - i) begin
                lzc = lzc + 1;
            end
        end
        fr  = (MW + 1)'(sum << lzc);
        sco = SW'(int'(scl) + 1 - lzc);
    end

    posit_encode #(.N(N), .es(es), .SW(SW), .FW(MW + 1)) u_enc (
        .sign(sl), .scale(sco), .frac(fr), .p(enc)
    );

    assign y    = (na || nb) ? {1'b1, {(N - 1){1'b0}}} :
                  za ? b :
                  zb ? a :
                  (sum == '0) ? '0 : enc;
    assign done = start;

endmodule

// File: rtl/posit_cmul_ctrl.sv
// Sequencer for the shared-core complex multiply: handshakes, product and
// sum capture strobes, and the operand-mux selects for the shared cores.
module posit_cmul_ctrl
    import posit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       out_ready,
    input  logic       triv_hit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       op_load,
    output logic       triv_load,
    output logic       mul_start,
    output logic       a_sel,
    output logic       b_sel,
    output logic [3:0] p_we,
    output logic       add_start,
    output logic       add_sel,
    output logic       yre_we,
    output logic       yim_we
);

    cmul_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        op_load   = 1'b0;
        triv_load = 1'b0;
        mul_start = 1'b0;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        p_we      = 4'b0000;
        add_start = 1'b0;
        add_sel   = 1'b0;
        yre_we    = 1'b0;
        yim_we    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_load   = 1'b1;
                    triv_load = triv_hit;
                    state_d   = triv_hit ? DONE : MUL0;
                end
            end
            MUL0: begin
                mul_start = 1'b1;
                p_we      = 4'b0001;
                state_d   = MUL1;
            end
            MUL1: begin
                mul_start = 1'b1;
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                p_we      = 4'b0010;
                state_d   = MUL2;
            end
            MUL2: begin
                mul_start = 1'b1;
                b_sel     = 1'b1;
                p_we      = 4'b0100;
                state_d   = MUL3;
            end
            MUL3: begin
                mul_start = 1'b1;
                a_sel     = 1'b1;
                p_we      = 4'b1000;
                state_d   = ADD_RE;
            end
            ADD_RE: begin
                add_start = 1'b1;
                yre_we    = 1'b1;
                state_d   = ADD_IM;
            end
            ADD_IM: begin
                add_start = 1'b1;
                add_sel   = 1'b1;
                yim_we    = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/posit_decode.sv
// Splits a posit into sign, flags, combined scale (k*2^es + e) and a
// left-aligned fraction with the hidden bit removed.
module posit_decode #(
    parameter int N  = 16,
    parameter int es = 3,
    parameter int SW = 10
) (
    input  logic [N-1:0]          p,
    output logic                  sign,
    output logic                  is_zero,
    output logic                  is_nar,
    output logic signed [SW-1:0]  scale,
    output logic [N-1:0]          frac
);

    logic [N-2:0]    rem;
    logic [N+es-1:0] shifted;
    logic [es-1:0]   exp_f;
    int              run;
    int              k;

    always_comb begin
        rem = p[N-1] ? (~p[N-2:0] + (N-1)'(1)) : p[N-2:0];
        run = 0;
        for (int i = N - 2; i >= 0; i--) begin
            if (rem[i] == rem[N-2] && run == N - 2 - i) begin
                run = run + 1;
            end
        end
        k = rem[N-2] ? run - 1 : -run;
        // Drop the regime run and its terminator; exponent then fraction follow.
        shifted = {rem, {(es + 1){1'b0}}} << (run + 1);
        exp_f   = shifted[N+es-1 -: es];
        frac    = shifted[N-1:0];
        scale   = SW'(k * (2 ** es) + int'(exp_f));
    end

    assign sign    = p[N-1];
    assign is_zero = (p == '0);
    assign is_nar  = (p == {1'b1, {(N - 1){1'b0}}});

endmodule

// File: rtl/posit_encode.sv
// Packs sign/scale/fraction into a posit with round-to-nearest-even,
// saturating to maxpos/minpos (posits never round to zero or NaR).
module posit_encode #(
    parameter int N  = 16,
    parameter int es = 3,
    parameter int SW = 10,
    parameter int FW = 33
) (
    input  logic                  sign,
    input  logic signed [SW-1:0]  scale,
    input  logic [FW-1:0]         frac,
    output logic [N-1:0]          p
);

    localparam int XW = 2 + es + FW + N;
    localparam logic signed [SW-1:0] KMAX = SW'(N - 2);

    logic signed [SW-1:0] k;
    logic [es-1:0]        e;
    logic signed [XW-1:0] x;
    logic [N-2:0]         body;
    logic                 rnd;
    logic                 stk;
    int                   sh;

    always_comb begin
        k    = scale >>> es;
        e    = scale[es-1:0];
        x    = '0;
        body = '0;
        rnd  = 1'b0;
        stk  = 1'b0;
        sh   = 0;
        if (k > KMAX) begin
            body = '1;
        end else if (k < -KMAX) begin
            body = (N - 1)'(1);
        end else begin
            // Arithmetic shift replicates the regime's leading bit k times.
            x    = {(k >= 0) ? 2'b10 : 2'b01, e, frac, {N{1'b0}}};
            sh   = (k >= 0) ? int'(k) : -int'(k) - 1;
            x    = x >>> sh;
            body = x[XW-1 -: N-1];
            rnd  = x[XW-N];
            stk  = |x[XW-N-1:0];
            body = body + (N - 1)'(rnd & (stk | body[0]));
        end
        p = sign ? -{1'b0, body} : {1'b0, body};
    end

endmodule

// File: rtl/posit_mult.sv
// Single-cycle combinational posit multiplier; done simply mirrors start.
module posit_mult #(
    parameter int N  = 16,
    parameter int es = 3
) (
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         done
);

    localparam int SW = $clog2(N) + es + 3;
    localparam int FW = 2 * N + 1;

    logic                 sa, sb, za, zb, na, nb;
    logic signed [SW-1:0] sca, scb, scp;
    logic [N-1:0]         fa, fb;
    logic [2*N+1:0]       prod;
    logic [FW-1:0]        frac_p;
    logic [N-1:0]         enc;

    posit_decode #(.N(N), .es(es), .SW(SW)) u_dec_a (
        .p(a), .sign(sa), .is_zero(za), .is_nar(na), .scale(sca), .frac(fa)
    );
    posit_decode #(.N(N), .es(es), .SW(SW)) u_dec_b (
        .p(b), .sign(sb), .is_zero(zb), .is_nar(nb), .scale(scb), .frac(fb)
    );

    always_comb begin
        prod   = (2 * N + 2)'({1'b1, fa}) * (2 * N + 2)'({1'b1, fb});
        scp    = sca + scb + $signed({{(SW - 1){1'b0}}, prod[2*N+1]});
        frac_p = prod[2*N+1] ? prod[2*N:0] : {prod[2*N-1:0], 1'b0};
    end

    posit_encode #(.N(N), .es(es), .SW(SW), .FW(FW)) u_enc (
        .sign(sa ^ sb), .scale(scp), .frac(frac_p), .p(enc)
    );

    assign y    = (na || nb) ? {1'b1, {(N - 1){1'b0}}} :
                  (za || zb) ? '0 : enc;
    assign done = start;

endmodule

// File: rtl/posit_cmul_seq.sv
// Sequential posit complex multiply y = a*w over one shared multiplier/adder.
// Optional POSIT_CMUL_TRIVIAL_TWIDDLE_EN bypasses the datapath for w = 1+0j.
module posit_cmul_seq
    import posit_pkg::*;
#(
    parameter int N  = 16,
    parameter int es = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_re,
    input  logic [N-1:0] a_im,
    input  logic [N-1:0] w_re,
    input  logic [N-1:0] w_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y_re,
    output logic [N-1:0] y_im,
    output logic         nar
);

    logic [N-1:0]        a_re_q, a_im_q, w_re_q, w_im_q;
    logic [3:0][N-1:0]   p_q;
    logic [N-1:0]        y_re_q, y_im_q;
    logic                nar_q;

    logic                op_load, triv_load, triv_hit;
    logic                mul_start, add_start, mul_done, add_done;
    logic                a_sel, b_sel, add_sel, yre_we, yim_we;
    logic [3:0]          p_we;
    logic [N-1:0]        mul_x, mul_y, mul_res, add_x, add_y, add_res;

`ifdef POSIT_CMUL_TRIVIAL_TWIDDLE_EN
    assign triv_hit = (w_re == POSIT_ONE) && (w_im == POSIT_ZERO);
`else
    assign triv_hit = 1'b0;
`endif

    posit_cmul_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .triv_hit  (triv_hit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .op_load   (op_load),
        .triv_load (triv_load),
        .mul_start (mul_start),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .p_we      (p_we),
        .add_start (add_start),
        .add_sel   (add_sel),
        .yre_we    (yre_we),
        .yim_we    (yim_we)
    );

    assign mul_x = a_sel ? a_im_q : a_re_q;
    assign mul_y = b_sel ? w_im_q : w_re_q;
    assign add_x = add_sel ? p_q[2] : p_q[0];
    assign add_y = add_sel ? p_q[3] : posit_neg(p_q[1]);

    posit_mult #(.N(N), .es(es)) u_mult (
        .start(mul_start), .a(mul_x), .b(mul_y), .y(mul_res), .done(mul_done)
    );
    posit_add #(.N(N), .es(es)) u_add (
        .start(add_start), .a(add_x), .b(add_y), .y(add_res), .done(add_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re_q <= '0;
            a_im_q <= '0;
            w_re_q <= '0;
            w_im_q <= '0;
            p_q    <= '0;
        end else begin
            if (op_load) begin
                a_re_q <= a_re;
                a_im_q <= a_im;
                w_re_q <= w_re;
                w_im_q <= w_im;
            end
            // done is high whenever start is, so it only qualifies the strobe.
            for (int i = 0; i < 4; i++) begin
                if (p_we[i] && mul_done) begin
                    p_q[i] <= mul_res;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_re_q <= '0;
            y_im_q <= '0;
            nar_q  <= 1'b0;
        end else if (triv_load) begin
            y_re_q <= a_re;
            y_im_q <= a_im;
            nar_q  <= (a_re == POSIT_NAR) || (a_im == POSIT_NAR);
        end else begin
            if (yre_we && add_done) begin
                y_re_q <= add_res;
            end
            if (yim_we && add_done) begin
                y_im_q <= add_res;
                nar_q  <= (y_re_q == POSIT_NAR) || (add_res == POSIT_NAR);
            end
        end
    end

    assign y_re = y_re_q;
    assign y_im = y_im_q;
    assign nar  = nar_q;

endmodule

// File: tb/tb_posit_cmul_seq.sv
// Directed vector bench for posit_cmul_seq: table of hand-computed products
// plus backpressure and mid-operation reset sequences.
module tb_posit_cmul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a_re = '0, a_im = '0, w_re = '0, w_im = '0;
    logic        in_ready, out_valid, nar;
    logic [15:0] y_re, y_im;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] a_re, a_im, w_re, w_im;
        logic [15:0] y_re, y_im;
        logic        nar;
        int          lat;   // edges after the accepting edge until out_valid is seen
    } vec_t;

    vec_t vecs[9];

    posit_cmul_seq #(.N(16), .es(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_im      (y_im),
        .nar       (nar)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int cyc;
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        a_re = v.a_re; a_im = v.a_im; w_re = v.w_re; w_im = v.w_im;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("v%0d_lat", idx), 32'(cyc), 32'(v.lat));
        chk($sformatf("v%0d_y_re", idx), 32'(y_re), 32'(v.y_re));
        chk($sformatf("v%0d_y_im", idx), 32'(y_im), 32'(v.y_im));
        chk($sformatf("v%0d_nar", idx), 32'(nar), 32'(v.nar));
        $display("op %0d: a=(%h,%h) w=(%h,%h) -> y=(%h,%h) nar=%b edges=%0d",
                 idx, v.a_re, v.a_im, v.w_re, v.w_im, y_re, y_im, nar, cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int seen;
        // (1+1j)(1-1j) = 2
        vecs[0] = '{16'h4000, 16'h4000, 16'h4000, 16'hC000, 16'h4400, 16'h0000, 1'b0, 6};
        // 2*2 = 4
        vecs[1] = '{16'h4400, 16'h0000, 16'h4400, 16'h0000, 16'h4800, 16'h0000, 1'b0, 6};
        // NaR operand poisons both halves
        vecs[2] = '{16'h8000, 16'h4000, 16'h4000, 16'h4000, 16'h8000, 16'h8000, 1'b1, 6};
        // (2+1j)^2 = 3+4j
        vecs[3] = '{16'h4400, 16'h4000, 16'h4400, 16'h4000, 16'h4600, 16'h4800, 1'b0, 6};
        // 0.5*2 = 1
        vecs[4] = '{16'h3C00, 16'h0000, 16'h4400, 16'h0000, 16'h4000, 16'h0000, 1'b0, 6};
        // 16*16 = 256, regime grows
        vecs[5] = '{16'h5000, 16'h0000, 16'h5000, 16'h0000, 16'h6000, 16'h0000, 1'b0, 6};
`ifdef POSIT_CMUL_TRIVIAL_TWIDDLE_EN
        // w = 1+0j bypass: valid in the cycle right after acceptance
        vecs[6] = '{16'h4400, 16'hC000, 16'h4000, 16'h0000, 16'h4400, 16'hC000, 1'b0, 0};
`else
        vecs[6] = '{16'h4400, 16'hC000, 16'h4000, 16'h0000, 16'h4400, 16'hC000, 1'b0, 6};
`endif
        // zero data
        vecs[7] = '{16'h0000, 16'h0000, 16'h4400, 16'h4400, 16'h0000, 16'h0000, 1'b0, 6};
        // (1+2j)^2 = -3+4j
        vecs[8] = '{16'h4000, 16'h4400, 16'h4000, 16'h4400, 16'hBA00, 16'h4800, 1'b0, 6};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y_re", 32'(y_re), 32'd0);
        chk("rst_y_im", 32'(y_im), 32'd0);
        chk("rst_nar", 32'(nar), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], i);
        end

        // Backpressure, with a spurious second operand set offered while busy
        a_re = vecs[3].a_re; a_im = vecs[3].a_im; w_re = vecs[3].w_re; w_im = vecs[3].w_im;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a_re = 16'h5000; a_im = 16'h5000; w_re = 16'h5000; w_im = 16'h5000;
        chk("bp_busy_in_ready", 32'(in_ready), 32'd0);
        cyc = 0;
        repeat (2) begin
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_lat", 32'(cyc), 32'd6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d_y_re", i), 32'(y_re), 32'h4600);
            chk($sformatf("bp%0d_y_im", i), 32'(y_im), 32'h4800);
        end
        $display("op bp: y=(%h,%h) held through 5 stalled cycles", y_re, y_im);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset asserted while the FSM is in MUL2
        a_re = vecs[8].a_re; a_im = vecs[8].a_im; w_re = vecs[8].w_re; w_im = vecs[8].w_im;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_y_re", 32'(y_re), 32'd0);
        chk("mr_y_im", 32'(y_im), 32'd0);
        chk("mr_nar", 32'(nar), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("mr_no_out_valid", 32'(seen), 32'd0);
        $display("op mr: reset in MUL2, %0d valid pulses afterwards", seen);
        run_op(vecs[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
